// File: rtl/subframe_sequencer_if.sv
// rtl/subframe_sequencer_if.sv - decoder-side bus between the sequencer and the subframe decoder
interface subframe_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              oDecReset;
  logic              oDecEnable;
  logic [ADDR_W-1:0] oRamReadAddr;
  logic              iDecFrameDone;
  logic              iDecSampleValid;
  logic [DATA_W-1:0] iDecSample;
  logic [ADDR_W-1:0] iDecReadAddr;

  // sequencer side
  modport master (
    output oDecReset, oDecEnable, oRamReadAddr,
    input  iDecFrameDone, iDecSampleValid, iDecSample, iDecReadAddr
  );

  // decoder side
  modport slave (
    input  oDecReset, oDecEnable, oRamReadAddr,
    output iDecFrameDone, iDecSampleValid, iDecSample, iDecReadAddr
  );
endinterface

// File: rtl/subframe_sequencer.sv
// rtl/subframe_sequencer.sv - walks a subframe decoder through every channel of one frame
module subframe_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int MAX_CH = 8
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iStart,
  input  logic                iAbort,
  input  logic [3:0]          iChannels,
  input  logic [15:0]         iBlockSize,
  input  logic [ADDR_W-1:0]   iFrameBase,
  subframe_sequencer_if.master dec,
  output logic [DATA_W-1:0]   oSample,
  output logic                oSampleValid,
  output logic [2:0]          oChannel,
  output logic [15:0]         oSampleIndex,
  output logic                oBusy,
  output logic                oDone,
  output logic                oError
);

  typedef enum logic [2:0] {S_IDLE, S_DEC_RST, S_RUN, S_NEXT, S_DONE} state_t;

  state_t            r_state;
  logic              r_rst_cnt;
  logic [3:0]        r_channels;
  logic [2:0]        r_chan;
  logic [15:0]       r_blk;
  logic [15:0]       r_count;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_next_base;
  logic              r_dec_reset;
  logic              r_dec_enable;

  logic [3:0]        w_ch_clamped;
  logic              w_accept;
  logic [15:0]       w_count_after;
  logic [ADDR_W-1:0] w_abs_addr;
  logic              w_last_chan;

  // channel count sanitising and per-cycle datapath helpers
  always_comb begin
    w_ch_clamped = iChannels;
    if (iChannels == 4'd0) begin
      w_ch_clamped = 4'd1;
    end else if (int'(iChannels) > MAX_CH) begin
      w_ch_clamped = 4'(MAX_CH);
    end
    w_accept      = dec.iDecSampleValid && (r_count != r_blk);
    w_count_after = r_count + {15'd0, w_accept};
    w_abs_addr    = r_base + dec.iDecReadAddr;
    w_last_chan   = ({1'b0, r_chan} == (r_channels - 4'd1));
  end

  assign dec.oRamReadAddr = w_abs_addr;
  assign dec.oDecReset    = r_dec_reset;
  assign dec.oDecEnable   = r_dec_enable;

  // frame sequencing FSM with registered outputs; abort outranks decoder events
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state      <= S_IDLE;
      r_rst_cnt    <= 1'b0;
      r_channels   <= 4'd1;
      r_chan       <= 3'd0;
      r_blk        <= 16'd0;
      r_count      <= 16'd0;
      r_base       <= '0;
      r_next_base  <= '0;
      r_dec_reset  <= 1'b1;
      r_dec_enable <= 1'b0;
      oSample      <= '0;
      oSampleValid <= 1'b0;
      oChannel     <= 3'd0;
      oSampleIndex <= 16'd0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oError       <= 1'b0;
    end else begin
      oSampleValid <= 1'b0;
      oDone        <= 1'b0;
      if (iAbort && (r_state != S_IDLE)) begin
        r_state      <= S_IDLE;
        r_dec_reset  <= 1'b1;
        r_dec_enable <= 1'b0;
        oBusy        <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (iStart) begin
              r_state    <= S_DEC_RST;
              r_channels <= w_ch_clamped;
              r_blk      <= iBlockSize;
              r_base     <= iFrameBase;
              r_chan     <= 3'd0;
              r_count    <= 16'd0;
              r_rst_cnt  <= 1'b0;
              oError     <= 1'b0;
              oBusy      <= 1'b1;
            end
          end
          S_DEC_RST: begin
            r_rst_cnt <= 1'b1;
            if (r_rst_cnt) begin
              r_state      <= S_RUN;
              r_dec_reset  <= 1'b0;
              r_dec_enable <= 1'b1;
            end
          end
          S_RUN: begin
            if (dec.iDecSampleValid) begin
              if (w_accept) begin
                oSampleValid <= 1'b1;
                oSample      <= dec.iDecSample;
                oChannel     <= r_chan;
                oSampleIndex <= r_count;
              end else begin
                oError <= 1'b1;
              end
            end
            r_count <= w_count_after;
            if (dec.iDecFrameDone) begin
              r_next_base  <= w_abs_addr + ADDR_W'(1);
              r_state      <= S_NEXT;
              r_dec_reset  <= 1'b1;
              r_dec_enable <= 1'b0;
              if (w_count_after != r_blk) begin
                oError <= 1'b1;
              end
            end
          end
          S_NEXT: begin
            r_base <= r_next_base;
            if (w_last_chan) begin
              r_state <= S_DONE;
              oDone   <= 1'b1;
            end else begin
              r_chan    <= r_chan + 3'd1;
              r_count   <= 16'd0;
              r_rst_cnt <= 1'b0;
              r_state   <= S_DEC_RST;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            oBusy   <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            oBusy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_subframe_sequencer.sv
// tb/tb_subframe_sequencer.sv - self-checking bench for subframe_sequencer
module tb_subframe_sequencer;

  logic        clk = 1'b0;
  logic        iReset, iStart, iAbort;
  logic [3:0]  iChannels;
  logic [15:0] iBlockSize, iFrameBase;
  logic [15:0] oSample, oSampleIndex;
  logic        oSampleValid, oBusy, oDone, oError;
  logic [2:0]  oChannel;

  subframe_sequencer_if #(.DATA_W(16), .ADDR_W(16)) dec ();

  subframe_sequencer #(.DATA_W(16), .ADDR_W(16), .MAX_CH(8)) dut (
    .iClock(clk), .iReset(iReset), .iStart(iStart), .iAbort(iAbort),
    .iChannels(iChannels), .iBlockSize(iBlockSize), .iFrameBase(iFrameBase),
    .dec(dec),
    .oSample(oSample), .oSampleValid(oSampleValid), .oChannel(oChannel),
    .oSampleIndex(oSampleIndex), .oBusy(oBusy), .oDone(oDone), .oError(oError)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ch;
    logic [15:0] idx;
    logic [15:0] smp;
  } out_t;

  typedef struct {
    int ch; int blk; int base; int n; int addr; bit coin; bit restart;
    int exp_nvalid; bit exp_err;
  } vec_t;

  out_t got_q[$];
  int   done_cnt;
  logic err_at_done;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   f_ch, f_blk, f_base, f_addr;
  int   f_n[8];
  bit   f_coin, f_restart;
  int   last_nvalid;
  logic last_err;

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (oSampleValid) got_q.push_back('{ch: oChannel, idx: oSampleIndex, smp: oSample});
    if (oDone) begin
      done_cnt++;
      err_at_done = oError;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_dec();
    dec.iDecSampleValid = 1'b0;
    dec.iDecFrameDone   = 1'b0;
    dec.iDecSample      = 16'd0;
    dec.iDecReadAddr    = 16'd0;
  endtask

  task automatic wait_enable(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (dec.oDecEnable) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_enable: got timeout expected oDecEnable=1");
    end
  endtask

  task automatic start_frame();
    got_q.delete();
    done_cnt   = 0;
    iStart     = 1'b1;
    iChannels  = 4'(f_ch);
    iBlockSize = 16'(f_blk);
    iFrameBase = 16'(f_base);
    tick();
    iStart = 1'b0;
  endtask

  // frame-level model: per channel, the first blk samples appear with index 0..blk-1;
  // any channel whose sample count differs from blk flags an error
  task automatic run_frame();
    int          eff, acc;
    bit          exp_err, ok, done_sent;
    logic [15:0] base, smp;
    out_t        exp_q[$];
    eff     = (f_ch == 0) ? 1 : ((f_ch > 8) ? 8 : f_ch);
    exp_err = 1'b0;
    base    = 16'(f_base);
    start_frame();
    chk("busy_after_start", {63'd0, oBusy}, 64'd1);
    chk("err_cleared", {63'd0, oError}, 64'd0);
    for (int c = 0; c < eff; c++) begin
      wait_enable(ok);
      if (!ok) begin
        iAbort = 1'b1; tick(); iAbort = 1'b0;
        return;
      end
      if (c == 0 && f_restart) begin
        iStart = 1'b1; iChannels = 4'd3; tick(); iStart = 1'b0;
      end
      acc = 0;
      done_sent = 1'b0;
      dec.iDecReadAddr = 16'd0;
      #1;
      chk("ram_addr_base", {48'd0, dec.oRamReadAddr}, {48'd0, base});
      for (int i = 0; i < f_n[c]; i++) begin
        smp = 16'($urandom);
        dec.iDecSampleValid = 1'b1;
        dec.iDecSample      = smp;
        dec.iDecReadAddr    = 16'(i);
        if (acc < f_blk) begin
          exp_q.push_back('{ch: 3'(c), idx: 16'(acc), smp: smp});
          acc++;
        end else begin
          exp_err = 1'b1;
        end
        if (i == f_n[c] - 1 && f_coin) begin
          dec.iDecFrameDone = 1'b1;
          dec.iDecReadAddr  = 16'(f_addr);
          done_sent = 1'b1;
        end
        tick();
        clear_dec();
        if ($urandom_range(0, 3) == 0) tick();
      end
      if (!done_sent) begin
        dec.iDecFrameDone = 1'b1;
        dec.iDecReadAddr  = 16'(f_addr);
        tick();
        clear_dec();
      end
      if (acc != f_blk) exp_err = 1'b1;
      base = base + 16'(f_addr) + 16'd1;
    end
    for (int k = 0; k < 10 && done_cnt == 0; k++) tick();
    tick();
    tick();
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("err_at_done", {63'd0, err_at_done}, {63'd0, exp_err});
    chk("err_sticky", {63'd0, oError}, {63'd0, exp_err});
    chk("busy_idle", {63'd0, oBusy}, 64'd0);
    chk("n_outputs", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("sample_rec", {29'd0, got_q[i]}, {29'd0, exp_q[i]});
    last_nvalid = got_q.size();
    last_err    = oError;
  endtask

  initial begin
    vec_t vecs[7];
    bit   ok;
    vecs[0] = '{ch: 2, blk: 4, base: 100,    n: 4, addr: 9, coin: 0, restart: 0, exp_nvalid: 8, exp_err: 0};
    vecs[1] = '{ch: 1, blk: 4, base: 0,      n: 3, addr: 9, coin: 0, restart: 0, exp_nvalid: 3, exp_err: 1};
    vecs[2] = '{ch: 1, blk: 4, base: 0,      n: 5, addr: 9, coin: 0, restart: 0, exp_nvalid: 4, exp_err: 1};
    vecs[3] = '{ch: 0, blk: 3, base: 50,     n: 3, addr: 5, coin: 0, restart: 1, exp_nvalid: 3, exp_err: 0};
    vecs[4] = '{ch: 9, blk: 1, base: 7,      n: 1, addr: 0, coin: 1, restart: 0, exp_nvalid: 8, exp_err: 0};
    vecs[5] = '{ch: 3, blk: 2, base: 'hFFFE, n: 2, addr: 3, coin: 1, restart: 0, exp_nvalid: 6, exp_err: 0};
    vecs[6] = '{ch: 2, blk: 0, base: 20,     n: 0, addr: 0, coin: 0, restart: 0, exp_nvalid: 0, exp_err: 0};

    iReset = 1'b1; iStart = 1'b0; iAbort = 1'b0;
    iChannels = 4'd0; iBlockSize = 16'd0; iFrameBase = 16'd0;
    clear_dec();
    done_cnt = 0;
    err_at_done = 1'b0;
    tick(); tick();
    iReset = 1'b0;
    chk("rst_dec_reset", {63'd0, dec.oDecReset}, 64'd1);
    chk("rst_dec_enable", {63'd0, dec.oDecEnable}, 64'd0);
    chk("rst_busy", {63'd0, oBusy}, 64'd0);
    chk("rst_valid", {63'd0, oSampleValid}, 64'd0);
    chk("rst_error", {63'd0, oError}, 64'd0);
    tick();

    // table-driven frames
    foreach (vecs[v]) begin
      f_ch = vecs[v].ch; f_blk = vecs[v].blk; f_base = vecs[v].base;
      f_addr = vecs[v].addr; f_coin = vecs[v].coin; f_restart = vecs[v].restart;
      for (int c = 0; c < 8; c++) f_n[c] = vecs[v].n;
      run_frame();
      chk("vec_nvalid", 64'(last_nvalid), 64'(vecs[v].exp_nvalid));
      chk("vec_err", {63'd0, last_err}, {63'd0, vecs[v].exp_err});
      tick();
    end

    // abort coincident with a sample in channel 0
    f_ch = 2; f_blk = 4; f_base = 0;
    start_frame();
    wait_enable(ok);
    dec.iDecSampleValid = 1'b1; dec.iDecSample = 16'hBEEF; iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    clear_dec();
    chk("abort_valid", {63'd0, oSampleValid}, 64'd0);
    chk("abort_busy", {63'd0, oBusy}, 64'd0);
    chk("abort_dec_reset", {63'd0, dec.oDecReset}, 64'd1);
    tick(); tick(); tick();
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_no_output", 64'(got_q.size()), 64'd0);

    // address wrap, then reset in the middle of RUN
    f_ch = 2; f_blk = 4; f_base = 'hFFFE;
    start_frame();
    wait_enable(ok);
    dec.iDecSampleValid = 1'b1; dec.iDecSample = 16'h1234; dec.iDecReadAddr = 16'd3;
    #1;
    chk("wrap_addr", {48'd0, dec.oRamReadAddr}, 64'h0001);
    tick();
    chk("pre_reset_valid", {63'd0, oSampleValid}, 64'd1);
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    chk("mid_rst_valid", {63'd0, oSampleValid}, 64'd0);
    chk("mid_rst_sample", {48'd0, oSample}, 64'd0);
    chk("mid_rst_chan", {61'd0, oChannel}, 64'd0);
    chk("mid_rst_index", {48'd0, oSampleIndex}, 64'd0);
    chk("mid_rst_busy", {63'd0, oBusy}, 64'd0);
    chk("mid_rst_done", {63'd0, oDone}, 64'd0);
    chk("mid_rst_error", {63'd0, oError}, 64'd0);
    chk("mid_rst_dec_reset", {63'd0, dec.oDecReset}, 64'd1);
    chk("mid_rst_dec_enable", {63'd0, dec.oDecEnable}, 64'd0);
    chk("mid_rst_base", {48'd0, dec.oRamReadAddr}, 64'd3);
    clear_dec();
    tick();

    // randomized frames against the frame-level model
    for (int r = 0; r < 25; r++) begin
      f_ch = int'($urandom_range(0, 15)); f_blk = int'($urandom_range(0, 6));
      f_base = int'($urandom_range(0, 65535)); f_addr = int'($urandom_range(0, 40));
      f_coin = 1'($urandom_range(0, 1)); f_restart = 1'($urandom_range(0, 1));
      for (int c = 0; c < 8; c++) f_n[c] = int'($urandom_range(0, 7));
      run_frame();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
